// File: rtl/dand_soc_pkg.sv
// dand_soc_pkg: shared constants, banner ROM and FSM state types for the
// dand_soc_simple UART bring-up shell.
package dand_soc_pkg;

    // Cycles per UART bit, truncated (30 MHz / 921600 -> 32).
    function automatic int unsigned calc_clks_per_bit(
        input int unsigned clk_freq,
        input int unsigned baud_rate
    );
        return clk_freq / baud_rate;
    endfunction

    localparam int unsigned BANNER_LEN = 9;

    // "DandSoc\r\n"; entry 0 is sent first.
    localparam logic [8:0][7:0] BANNER = {
        8'h0A, 8'h0D, 8'h63, 8'h6F, 8'h53,
        8'h64, 8'h6E, 8'h61, 8'h44
    };

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic {
        MODE_BOOT,
        MODE_ECHO
    } mode_e;

endpackage

// File: rtl/dand_uart_core.sv
// dand_uart_core: 8N1 UART transmitter and receiver, RX->TX byte FIFO and a
// 32-bit retire counter that counts completed TX frames.
// Ports: clk, rst (sync, active high), rxd (async in), txd (out, idle high),
//   tx_req/tx_byte/tx_ready (TX load handshake), fifo_pop/fifo_empty/fifo_head.
module dand_uart_core
    import dand_soc_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 32,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       txd,
    input  logic       tx_req,
    input  logic [7:0] tx_byte,
    output logic       tx_ready,
    input  logic       fifo_pop,
    output logic       fifo_empty,
    output logic [7:0] fifo_head
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    // ---------------- TX ----------------
    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          txd_q, txd_d;
    logic          tx_last;
    logic          tx_fire;
    logic [31:0]   retire_cnt;
    logic [31:0]   retire_cnt_d;

    assign tx_last = (tx_cnt_q == BIT_LAST);
    assign txd     = txd_q;

    // Ready also in the last stop cycle so frames chain with no idle gap.
    assign tx_ready = (tx_state_q == TX_IDLE) ||
                      ((tx_state_q == TX_STOP) && tx_last);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        txd_d      = txd_q;
        tx_fire    = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: tx_cnt_d = '0;
            TX_START: begin
                if (tx_last) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_sh_q[0];
                end
            end
            TX_DATA: begin
                if (tx_last) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        txd_d    = tx_sh_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_last) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = '0;
                    tx_fire    = 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_ready && tx_req) begin
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_sh_d    = tx_byte;
            txd_d      = 1'b0;
        end
    end

    assign retire_cnt_d = tx_fire ? retire_cnt + 32'd1 : retire_cnt;

    // ---------------- RX ----------------
    logic          rx_s1_q, rx_s2_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_push;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                // Line back high at mid start bit: treat as a glitch.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else rx_bit_d = rx_bit_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    rx_push    = rx_s2_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- FIFO ----------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full, wr_en, rd_en;

    assign full       = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = mem_q[rd_ptr_q];
    assign wr_en      = rx_push && !full;
    assign rd_en      = fifo_pop && !fifo_empty;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= rx_sh_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
            retire_cnt <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            txd_q      <= txd_d;
            retire_cnt <= retire_cnt_d;
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: rtl/dand_soc_simple.sv
// dand_soc_simple: bring-up SoC shell; sends "DandSoc\r\n" after reset, then
// echoes received UART bytes. Define DAND_SOC_ECHO_UPCASE_EN to upper-case
// echoed a..z. Ports: io_axiClk, io_reset (sync, active high),
// io_uart_txd (out, idle high), io_uart_rxd (async in, idle high).
module dand_soc_simple
    import dand_soc_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 30_000_000,
    parameter int unsigned BAUD_RATE  = 921_600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic io_axiClk,
    input  logic io_reset,
    output logic io_uart_txd,
    input  logic io_uart_rxd
);

    localparam int unsigned CPB = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);

    mode_e      mode_q, mode_d;
    logic [3:0] idx_q, idx_d;
    logic       tx_req, tx_ready, fifo_pop, fifo_empty;
    logic [7:0] tx_byte, fifo_head, echo_byte;

`ifdef DAND_SOC_ECHO_UPCASE_EN
    assign echo_byte = (fifo_head >= 8'h61 && fifo_head <= 8'h7A) ?
                       fifo_head - 8'h20 : fifo_head;
`else
    assign echo_byte = fifo_head;
`endif

    always_comb begin
        mode_d   = mode_q;
        idx_d    = idx_q;
        tx_req   = 1'b0;
        tx_byte  = BANNER[idx_q];
        fifo_pop = 1'b0;
        if (mode_q == MODE_BOOT) begin
            if (tx_ready) begin
                tx_req = 1'b1;
                if (idx_q == 4'(BANNER_LEN - 1)) mode_d = MODE_ECHO;
                else idx_d = idx_q + 1'b1;
            end
        end else begin
            tx_byte = echo_byte;
            if (tx_ready && !fifo_empty) begin
                tx_req   = 1'b1;
                fifo_pop = 1'b1;
            end
        end
    end

    always_ff @(posedge io_axiClk) begin
        if (io_reset) begin
            mode_q <= MODE_BOOT;
            idx_q  <= '0;
        end else begin
            mode_q <= mode_d;
            idx_q  <= idx_d;
        end
    end

    dand_uart_core #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) core_cpu (
        .clk       (io_axiClk),
        .rst       (io_reset),
        .rxd       (io_uart_rxd),
        .txd       (io_uart_txd),
        .tx_req    (tx_req),
        .tx_byte   (tx_byte),
        .tx_ready  (tx_ready),
        .fifo_pop  (fifo_pop),
        .fifo_empty(fifo_empty),
        .fifo_head (fifo_head)
    );

endmodule

// File: tb/tb_dand_soc_simple.sv
// tb_dand_soc_simple: drives UART frames into dand_soc_simple and decodes
// its TX line against an expected-byte queue.
module tb_dand_soc_simple;

    logic clk = 1'b0;
    logic io_reset = 1'b1;
    logic rxd = 1'b1;
    logic txd;

    always #5 clk = ~clk;

    dand_soc_simple dut (
        .io_axiClk  (clk),
        .io_reset   (io_reset),
        .io_uart_txd(txd),
        .io_uart_rxd(rxd)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int gen = 0;
    int frames_done = 0;
    int frames_since_rst = 0;
    int rel_cyc = 0;
    int last_start = 0;
    int fire_cnt = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (io_reset) fire_cnt = 0;
        else if (dut.core_cpu.tx_fire) fire_cnt = fire_cnt + 1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef DAND_SOC_ECHO_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    task automatic push_banner();
        exp_q.push_back(8'h44); exp_q.push_back(8'h61);
        exp_q.push_back(8'h6E); exp_q.push_back(8'h64);
        exp_q.push_back(8'h53); exp_q.push_back(8'h6F);
        exp_q.push_back(8'h63); exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic mon_wait(input int n, input int g, output bit ab);
        ab = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (gen != g) begin
                ab = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_frame(input int st, input logic s0,
                               input logic [7:0] b, input logic sb);
        logic [7:0] e;
        chk("frame_start_stop", {s0, sb}, 2'b01);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame: got %0h expected none", b);
        end else begin
            e = exp_q.pop_front();
            chk("tx_byte", b, e);
        end
        if (frames_since_rst == 0) chk("boot_start_cycle", st - rel_cyc, 1);
        else if (frames_since_rst <= 8) chk("banner_frame_len", st - last_start, 320);
        last_start = st;
        frames_since_rst++;
        frames_done++;
    endtask

    // TX line decoder: samples each bit at its middle.
    initial begin : decoder
        forever begin
            @(negedge clk);
            if (!io_reset && txd == 1'b0) begin
                int g;
                int st;
                bit ab;
                logic s0;
                logic sb;
                logic [7:0] b;
                g = gen;
                st = cyc;
                b = '0;
                sb = 1'b0;
                mon_wait(16, g, ab);
                s0 = txd;
                for (int i = 0; i < 8; i++) begin
                    if (!ab) begin
                        mon_wait(32, g, ab);
                        b[i] = txd;
                    end
                end
                if (!ab) begin
                    mon_wait(32, g, ab);
                    sb = txd;
                end
                if (!ab) check_frame(st, s0, b, sb);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (32) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (32) @(negedge clk);
        end
        rxd = stop;
        repeat (32) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic release_reset();
        exp_q.delete();
        push_banner();
        frames_since_rst = 0;
        frames_done = 0;
        rel_cyc = cyc;
        io_reset = 1'b0;
    endtask

    task automatic drain(input int lim);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (40) @(negedge clk);
    endtask

    initial begin
        int k;
        int lows;
        repeat (5) @(negedge clk);
        chk("reset_txd", txd, 1);
        chk("reset_retire", dut.core_cpu.retire_cnt, 0);

        // Banner, with six bytes arriving while it is being sent.
        release_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(echo_of(8'h31 + 8'(i)));
        repeat (10) @(negedge clk);
        for (int i = 0; i < 6; i++) send_byte(8'h31 + 8'(i), 1'b1);
        k = 0;
        while (frames_done < 9 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("banner_frames", frames_done >= 9, 1);
        repeat (20) @(negedge clk);
        chk("banner_retire", dut.core_cpu.retire_cnt, 9);
        drain(5000);
        chk("overflow_retire", dut.core_cpu.retire_cnt, 13);
        chk("fire_pulses", fire_cnt, frames_done);

        // Plain echo.
        exp_q.push_back(8'h41);
        send_byte(8'h41, 1'b1);
        drain(2000);
        chk("echo_retire", dut.core_cpu.retire_cnt, 14);

        // Case boundaries.
        exp_q.push_back(8'h60);
        exp_q.push_back(echo_of(8'h61));
        exp_q.push_back(echo_of(8'h7A));
        exp_q.push_back(8'h7B);
        send_byte(8'h60, 1'b1);
        send_byte(8'h61, 1'b1);
        send_byte(8'h7A, 1'b1);
        send_byte(8'h7B, 1'b1);
        drain(3000);
        chk("bound_retire", dut.core_cpu.retire_cnt, 18);

        // Framing error then a good byte.
        send_byte(8'h55, 1'b0);
        repeat (64) @(negedge clk);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        drain(2000);
        chk("framing_retire", dut.core_cpu.retire_cnt, 19);

        // Short low glitch on idle rxd.
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        rxd = 1'b1;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (txd == 1'b0) lows++;
        end
        chk("glitch_txd_idle", lows, 0);
        chk("glitch_retire", dut.core_cpu.retire_cnt, 19);

        // Reset in the middle of an echo frame.
        exp_q.push_back(8'h42);
        send_byte(8'h42, 1'b1);
        repeat (50) @(negedge clk);
        gen++;
        exp_q.delete();
        io_reset = 1'b1;
        @(negedge clk);
        chk("abort_txd", txd, 1);
        chk("abort_retire", dut.core_cpu.retire_cnt, 0);
        repeat (2) @(negedge clk);
        release_reset();
        drain(4000);
        chk("restart_retire", dut.core_cpu.retire_cnt, 9);
        chk("restart_frames", frames_done, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
